// File: rtl/sad_sequencer.sv
// sad_sequencer: instruction sequencer for a bank of SAD engines.
// Decodes CLEAR / SAD / HALT / CLRERR in IDLE, pulses the engines, and
// waits for every engine to report done before releasing the PC.
// All outputs come straight from flops.
// Optional feature macro: SAD_SEQ_TIMEOUT_EN adds a WAIT-state watchdog
// with a sticky TimeoutErr flag. Without it, TimeoutErr is tied low and
// CLRERR decodes as a NOP.
module sad_sequencer #(
  parameter int OPCODE_W    = 3,
  parameter int NUM_ENGINES = 2,
  parameter int TIMEOUT_W   = 8
) (
  input  logic                   Clk,
  input  logic                   Rst_n,
  input  logic [OPCODE_W-1:0]    OPCode,
  input  logic                   InstrValid,
  input  logic [NUM_ENGINES-1:0] EngDone,
  output logic                   SetZeroes,
  output logic [NUM_ENGINES-1:0] TriggerBoss,
  output logic                   PCStall,
  output logic                   Busy,
  output logic                   SadDone,
  output logic                   TimeoutErr
);

  // Catch illegal configurations at elaboration time.
  if (OPCODE_W < 3 || NUM_ENGINES < 1 || NUM_ENGINES > 8 || TIMEOUT_W < 1) begin : g_param_chk
    $error("sad_sequencer: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [2:0] OP_CLEAR  = 3'b100;
  localparam logic [2:0] OP_SAD    = 3'b101;
  localparam logic [2:0] OP_HALT   = 3'b110;
  localparam logic [2:0] OP_CLRERR = 3'b111;

  state_t                 state_q, state_d;
  logic [NUM_ENGINES-1:0] done_q, done_d;
  logic                   setz_q, setz_d;
  logic [NUM_ENGINES-1:0] trig_q, trig_d;
  logic                   pcst_q, pcst_d;
  logic                   busy_q, busy_d;
  logic                   sadd_q, sadd_d;

  // Decode: any set bit above bit 2 turns the instruction into a NOP.
  logic       hi_nz;
  logic [2:0] op;
  logic       accept;
  logic       all_done;

  assign hi_nz    = |(OPCode >> 3);
  assign op       = OPCode[2:0];
  assign accept   = InstrValid && !hi_nz && (state_q == S_IDLE);
  assign all_done = &(done_q | EngDone);

`ifdef SAD_SEQ_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] cnt_inc;
  logic                 terr_q, terr_d;
  logic                 to_hit;

  assign cnt_inc = cnt_q + 1'b1;
  // Counter would reach all ones on this WAIT cycle.
  assign to_hit  = &cnt_inc;
`endif

  // Next-state logic; output flops are derived from the next state so
  // every output lines up with the state it describes.
  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    sadd_d  = 1'b0;
`ifdef SAD_SEQ_TIMEOUT_EN
    cnt_d   = cnt_q;
    terr_d  = terr_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (op)
            OP_CLEAR:  state_d = S_CLEAR;
            OP_SAD:    state_d = S_LAUNCH;
            OP_HALT:   state_d = S_HALT;
`ifdef SAD_SEQ_TIMEOUT_EN
            OP_CLRERR: terr_d  = 1'b0;
`else
            OP_CLRERR: state_d = S_IDLE;
`endif
            default:   state_d = S_IDLE;
          endcase
        end
      end
      S_CLEAR: state_d = S_IDLE;
      S_LAUNCH: begin
        // Engine done flags seen while launching are stale; start clean.
        state_d = S_WAIT;
        done_d  = '0;
`ifdef SAD_SEQ_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (all_done) begin
          // Completion wins over a coincident timeout.
          state_d = S_IDLE;
          sadd_d  = 1'b1;
          done_d  = '0;
`ifdef SAD_SEQ_TIMEOUT_EN
          cnt_d   = '0;
        end else if (to_hit) begin
          state_d = S_IDLE;
          terr_d  = 1'b1;
          done_d  = '0;
          cnt_d   = '0;
`endif
        end else begin
          done_d = done_q | EngDone;
`ifdef SAD_SEQ_TIMEOUT_EN
          cnt_d  = cnt_inc;
`endif
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    setz_d = (state_d == S_CLEAR);
    trig_d = (state_d == S_LAUNCH) ? {NUM_ENGINES{1'b1}} : '0;
    pcst_d = (state_d == S_LAUNCH) || (state_d == S_WAIT) || (state_d == S_HALT);
    busy_d = (state_d != S_IDLE);
  end

  // State and sticky done vector.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      setz_q <= 1'b0;
      trig_q <= '0;
      pcst_q <= 1'b0;
      busy_q <= 1'b0;
      sadd_q <= 1'b0;
    end else begin
      setz_q <= setz_d;
      trig_q <= trig_d;
      pcst_q <= pcst_d;
      busy_q <= busy_d;
      sadd_q <= sadd_d;
    end
  end

`ifdef SAD_SEQ_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
    end
  end

  assign TimeoutErr = terr_q;
`else
  assign TimeoutErr = 1'b0;
`endif

  assign SetZeroes   = setz_q;
  assign TriggerBoss = trig_q;
  assign PCStall     = pcst_q;
  assign Busy        = busy_q;
  assign SadDone     = sadd_q;

endmodule
